// File: rtl/ahb_mem_slave_if.sv
// AHB-Lite slave-side bus bundle for ahb_mem_slave; master drives the address/data phase, slave answers.
interface ahb_mem_slave_if;
   logic        HSEL;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [31:0] HWDATA;
   logic        HREADY;
   logic [31:0] HRDATA;
   logic        HREADYOUT;
   logic        HRESP;

   modport master (
      output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
      input  HRDATA, HREADYOUT, HRESP
   );

   modport slave (
      input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
      output HRDATA, HREADYOUT, HRESP
   );
endinterface

// File: rtl/ahb_mem_slave.sv
// AHB-Lite word memory with WAIT_CYCLES data-phase wait states and back-to-back transfers.
// Define AHB_MEM_ERR_EN to answer bad size, misaligned or out-of-range transfers with a two-cycle ERROR.
module ahb_mem_slave #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned WAIT_CYCLES = 3
) (
   input  logic           clk,
   input  logic           reset,
   ahb_mem_slave_if.slave ahb
);
   localparam int unsigned AW    = $clog2(DEPTH_WORDS);
   localparam int unsigned CNT_W = 4;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

   typedef enum logic [2:0] {IDLE, WAIT, DONE, ERR1, ERR2} state_t;

   typedef struct packed {
      logic [AW-1:0] idx;
      logic [1:0]    lane;
      logic [2:0]    size;
      logic          write;
   } xfer_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   xfer_t            xfer_q, xfer_d;
   logic [31:0]      hrdata_q, hrdata_d;
   logic             hreadyout_q, hreadyout_d;
   logic             hresp_q, hresp_d;
   logic [31:0]      mem [DEPTH_WORDS];

   logic             accept_c, err_c, commit_c, rd_load_c;
   logic [AW-1:0]    bus_idx_c, tgt_idx_c;
   logic [3:0]       be_c;
   logic [31:0]      rd_word_c;
   logic             unused_bits;

   // Byte-lane enables; halfword ignores HADDR[0] and wide sizes fall back to a full word.
   function automatic logic [3:0] lanes(input logic [2:0] size, input logic [1:0] lane);
      case (size)
         3'd0:    return 4'b0001 << lane;
         3'd1:    return lane[1] ? 4'b1100 : 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   assign bus_idx_c = ahb.HADDR[AW+1:2];
   assign accept_c  = ((state_q == IDLE) || (state_q == DONE) || (state_q == ERR2)) &&
                      ahb.HSEL && ahb.HTRANS[1] && ahb.HREADY;
   assign commit_c  = (state_q == DONE) && xfer_q.write;
   assign be_c      = lanes(xfer_q.size, xfer_q.lane);

`ifdef AHB_MEM_ERR_EN
   assign err_c = (ahb.HSIZE > 3'd2) ||
                  ((ahb.HSIZE == 3'd1) && ahb.HADDR[0]) ||
                  ((ahb.HSIZE == 3'd2) && (ahb.HADDR[1:0] != 2'b00)) ||
                  (64'(ahb.HADDR) >= 64'(DEPTH_WORDS) * 64'd4);
`else
   assign err_c = 1'b0;
`endif

   assign unused_bits = ^{ahb.HTRANS[0], ahb.HADDR};

   // Next state, wait counter, captured address phase and registered-output values.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      xfer_d      = xfer_q;
      hreadyout_d = 1'b1;
      hresp_d     = 1'b0;
      case (state_q)
         WAIT: begin
            if (cnt_q == '0) state_d = DONE;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         ERR1: state_d = ERR2;
         default: begin
            state_d = IDLE;
            if (accept_c) begin
               if (err_c) begin
                  state_d = ERR1;
               end else begin
                  xfer_d = '{idx: bus_idx_c, lane: ahb.HADDR[1:0], size: ahb.HSIZE, write: ahb.HWRITE};
                  if (WAIT_CYCLES > 0) begin
                     state_d = WAIT;
                     cnt_d   = CNT_LOAD;
                  end else begin
                     state_d = DONE;
                  end
               end
            end
         end
      endcase
      hreadyout_d = !((state_d == WAIT) || (state_d == ERR1));
      hresp_d     = (state_d == ERR1) || (state_d == ERR2);
   end

   // Read data for the transfer entering DONE, forwarding a write that commits on the same edge.
   always_comb begin
      tgt_idx_c = (state_q == WAIT) ? xfer_q.idx : bus_idx_c;
      rd_word_c = mem[tgt_idx_c];
      if (commit_c && (xfer_q.idx == tgt_idx_c)) begin
         for (int b = 0; b < 4; b++) begin
            if (be_c[b]) rd_word_c[8*b +: 8] = ahb.HWDATA[8*b +: 8];
         end
      end
      rd_load_c = (state_d == DONE) && ((state_q == WAIT) ? !xfer_q.write : !ahb.HWRITE);
      hrdata_d  = rd_load_c ? rd_word_c : hrdata_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         xfer_q      <= '0;
         hrdata_q    <= '0;
         hreadyout_q <= 1'b1;
         hresp_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         xfer_q      <= xfer_d;
         hrdata_q    <= hrdata_d;
         hreadyout_q <= hreadyout_d;
         hresp_q     <= hresp_d;
      end
   end

   // Storage is not reset; writes land at the end of the DONE cycle only.
   always_ff @(posedge clk) begin
      if (commit_c) begin
         for (int b = 0; b < 4; b++) begin
            if (be_c[b]) mem[xfer_q.idx][8*b +: 8] <= ahb.HWDATA[8*b +: 8];
         end
      end
   end

   assign ahb.HRDATA    = hrdata_q;
   assign ahb.HREADYOUT = hreadyout_q;
   assign ahb.HRESP     = hresp_q;
endmodule

// File: tb/tb_ahb_mem_slave.sv
// Scoreboard bench for ahb_mem_slave: one instance with 3 wait states, one with none.
module tb_ahb_mem_slave;
   localparam int N      = 2;
   localparam int LIMIT  = 4000;
   localparam logic [1:0] IDLE_T = 2'b00;
   localparam logic [1:0] BUSY_T = 2'b01;
   localparam logic [1:0] NSEQ_T = 2'b10;

   typedef struct {
      string       name;
      bit          is_read;
      logic [31:0] data;
      bit          resp;
      int          waits;
      bit          abort;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [N-1:0] hsel, hwrite, hrdy, hresp;
   logic [1:0]  htrans [N];
   logic [2:0]  hsize  [N];
   logic [31:0] haddr  [N];
   logic [31:0] hwdata [N];
   logic [31:0] hrdata [N];

   exp_t sbq0[$];
   exp_t sbq1[$];
   bit   dp_active [N];
   int   waits [N];
   int   checks = 0;
   int   failures = 0;
   int   drv_err = 0;
   int   cycles = 0;
   bit   done = 1'b0;
   bit   reset_seen = 1'b0;

   always #5 clk = ~clk;

   ahb_mem_slave_if bus3 ();
   ahb_mem_slave_if bus0 ();

   assign bus3.HSEL   = hsel[0];
   assign bus3.HADDR  = haddr[0];
   assign bus3.HTRANS = htrans[0];
   assign bus3.HWRITE = hwrite[0];
   assign bus3.HSIZE  = hsize[0];
   assign bus3.HWDATA = hwdata[0];
   assign bus3.HREADY = bus3.HREADYOUT;
   assign hrdy[0]     = bus3.HREADYOUT;
   assign hresp[0]    = bus3.HRESP;
   assign hrdata[0]   = bus3.HRDATA;

   assign bus0.HSEL   = hsel[1];
   assign bus0.HADDR  = haddr[1];
   assign bus0.HTRANS = htrans[1];
   assign bus0.HWRITE = hwrite[1];
   assign bus0.HSIZE  = hsize[1];
   assign bus0.HWDATA = hwdata[1];
   assign bus0.HREADY = bus0.HREADYOUT;
   assign hrdy[1]     = bus0.HREADYOUT;
   assign hresp[1]    = bus0.HRESP;
   assign hrdata[1]   = bus0.HRDATA;

   ahb_mem_slave #(.DEPTH_WORDS(256), .WAIT_CYCLES(3)) dut3 (.clk(clk), .reset(reset), .ahb(bus3));
   ahb_mem_slave #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut0 (.clk(clk), .reset(reset), .ahb(bus0));

   task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s dut%0d actual=0x%08h expected=0x%08h", name, k, act, exp);
      end
   endtask

   function automatic int qsize(input int k);
      return (k == 0) ? sbq0.size() : sbq1.size();
   endfunction

   task automatic pop_exp(input int k, output exp_t it);
      if (k == 0) it = sbq0.pop_front();
      else        it = sbq1.pop_front();
   endtask

   // Monitor: tracks each data phase, counts wait cycles and compares at completion or reset.
   always @(negedge clk) begin
      exp_t it;
      cycles++;
      for (int k = 0; k < N; k++) begin
         if (reset) begin
            if (!reset_seen) begin
               chk("reset_hreadyout", k, 32'(hrdy[k]), 32'd1);
               chk("reset_hresp", k, 32'(hresp[k]), 32'd0);
               chk("reset_hrdata", k, hrdata[k], 32'd0);
               if (dp_active[k]) begin
                  if (qsize(k) == 0) chk("abort_without_expect", k, 32'd1, 32'd0);
                  else begin
                     pop_exp(k, it);
                     chk({it.name, "_aborted"}, k, 32'(it.abort), 32'd1);
                  end
               end
            end
            dp_active[k] = 1'b0;
         end else begin
            if (dp_active[k]) begin
               if (!hrdy[k]) waits[k]++;
               else begin
                  dp_active[k] = 1'b0;
                  if (qsize(k) == 0) chk("unexpected_completion", k, 32'd1, 32'd0);
                  else begin
                     pop_exp(k, it);
                     chk({it.name, "_waits"}, k, 32'(waits[k]), 32'(it.waits));
                     chk({it.name, "_hresp"}, k, 32'(hresp[k]), 32'(it.resp));
                     if (it.is_read && !it.resp) chk({it.name, "_hrdata"}, k, hrdata[k], it.data);
                  end
               end
            end
            if (hrdy[k] && hsel[k] && (htrans[k] != IDLE_T)) begin
               dp_active[k] = 1'b1;
               waits[k]     = 0;
            end
         end
      end
      reset_seen = reset;
      if (done || cycles > LIMIT) begin
         if (cycles > LIMIT) begin
            failures++;
            $display("FAIL watchdog cycles=%0d limit=%0d", cycles, LIMIT);
         end
         chk("queue0_drained", 0, 32'(sbq0.size()), 32'd0);
         chk("queue1_drained", 1, 32'(sbq1.size()), 32'd0);
         chk("driver_timeouts", 0, 32'(drv_err), 32'd0);
         $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
         $finish;
      end
   end

   // Wait until the slave is ready at a negedge, then step past the accepting edge.
   task automatic wait_ready(input int k);
      int n = 0;
      @(negedge clk);
      while (!hrdy[k] && n < 64) begin
         n++;
         @(negedge clk);
      end
      if (!hrdy[k]) drv_err++;
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input int k, input string name, input bit wr, input logic [31:0] addr,
                        input logic [2:0] size, input logic [1:0] trans, input logic [31:0] wdata,
                        input logic [31:0] exp_data, input bit exp_resp, input int exp_waits,
                        input bit abort);
      exp_t it;
      hsel[k]   = 1'b1;
      haddr[k]  = addr;
      hwrite[k] = wr;
      hsize[k]  = size;
      htrans[k] = trans;
      it.name    = name;
      it.is_read = !wr;
      it.data    = exp_data;
      it.resp    = exp_resp;
      it.waits   = exp_waits;
      it.abort   = abort;
      if (k == 0) sbq0.push_back(it);
      else        sbq1.push_back(it);
      wait_ready(k);
      hwdata[k] = wdata;
   endtask

   task automatic go_idle(input int k);
      hsel[k]   = 1'b0;
      htrans[k] = IDLE_T;
      hwrite[k] = 1'b0;
      wait_ready(k);
   endtask

   task automatic wr(input int k, input string name, input logic [31:0] addr, input logic [2:0] size,
                     input logic [31:0] data, input int exp_waits);
      issue(k, name, 1'b1, addr, size, NSEQ_T, data, 32'd0, 1'b0, exp_waits, 1'b0);
   endtask

   task automatic rd(input int k, input string name, input logic [31:0] addr, input logic [31:0] exp,
                     input bit exp_resp, input int exp_waits);
      issue(k, name, 1'b0, addr, 3'd2, NSEQ_T, 32'd0, exp, exp_resp, exp_waits, 1'b0);
   endtask

   initial begin
      reset  = 1'b1;
      hsel   = '0;
      hwrite = '0;
      for (int k = 0; k < N; k++) begin
         htrans[k] = IDLE_T;
         hsize[k]  = 3'd2;
         haddr[k]  = 32'd0;
         hwdata[k] = 32'd0;
      end
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // Word write/read with three wait states each.
      wr(0, "wr_0x10", 32'h10, 3'd2, 32'hDEADBEEF, 3);
      rd(0, "rd_0x10", 32'h10, 32'hDEADBEEF, 1'b0, 3);
      // Byte lane 3 over an existing word.
      wr(0, "wr_0x10_base", 32'h10, 3'd2, 32'h11223344, 3);
      wr(0, "wr_byte_0x13", 32'h13, 3'd0, 32'hAA000000, 3);
      rd(0, "rd_byte_merge", 32'h10, 32'hAA223344, 1'b0, 3);
      // Upper halfword lane.
      wr(0, "wr_0x14_base", 32'h14, 3'd2, 32'h01020304, 3);
      wr(0, "wr_half_0x16", 32'h16, 3'd1, 32'hBEEF0000, 3);
      rd(0, "rd_half_merge", 32'h14, 32'hBEEF0304, 1'b0, 3);
      // BUSY between NONSEQ transfers: zero-wait OKAY and no write.
      wr(0, "wr_0x40", 32'h40, 3'd2, 32'h12345678, 3);
      issue(0, "busy_0x40", 1'b1, 32'h40, 3'd2, BUSY_T, 32'hFFFFFFFF, 32'd0, 1'b0, 0, 1'b0);
      rd(0, "rd_0x40_after_busy", 32'h40, 32'h12345678, 1'b0, 3);
      // Misaligned and out-of-range reads.
      wr(0, "wr_0x00", 32'h00, 3'd2, 32'hCAFEF00D, 3);
`ifdef AHB_MEM_ERR_EN
      rd(0, "rd_misaligned", 32'h02, 32'd0, 1'b1, 1);
      rd(0, "rd_out_of_range", 32'h400, 32'd0, 1'b1, 1);
`else
      rd(0, "rd_misaligned", 32'h02, 32'hCAFEF00D, 1'b0, 3);
      rd(0, "rd_out_of_range", 32'h400, 32'hCAFEF00D, 1'b0, 3);
`endif
      go_idle(0);

      // Reset in the second wait cycle of a write aborts it.
      wr(0, "wr_0x30_old", 32'h30, 3'd2, 32'h5A5A0001, 3);
      go_idle(0);
      issue(0, "wr_0x30_aborted", 1'b1, 32'h30, 3'd2, NSEQ_T, 32'hFFFFFFFF, 32'd0, 1'b0, 3, 1'b1);
      hsel[0]   = 1'b0;
      htrans[0] = IDLE_T;
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      rd(0, "rd_0x30_after_reset", 32'h30, 32'h5A5A0001, 1'b0, 3);
      go_idle(0);

      // Zero-wait instance: back-to-back write then read, including a partial-lane forward.
      wr(1, "b2b_wr_0x20", 32'h20, 3'd2, 32'h0BADCAFE, 0);
      rd(1, "b2b_rd_0x20", 32'h20, 32'h0BADCAFE, 1'b0, 0);
      wr(1, "wr_0x24_base", 32'h24, 3'd2, 32'h11111111, 0);
      wr(1, "b2b_wr_byte_0x25", 32'h25, 3'd0, 32'h00002200, 0);
      rd(1, "b2b_rd_0x24_fwd", 32'h24, 32'h11112211, 1'b0, 0);
      go_idle(1);

      repeat (2) @(posedge clk);
      done = 1'b1;
   end
endmodule
